// File: rtl/bk_pkg.sv
// Shared types and constants for the backup-RAM SD sequencer.
package bk_pkg;

    localparam int SECTOR_BYTES = 512;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        FINISH    = 3'd4
    } bk_state_t;

endpackage

// File: rtl/bk_sd_sequencer.sv
// Moves a SECTORS x 512-byte backup image between save RAM and the SD image via user_io.
// Optional feature: define BK_AUTOSAVE_EN to save dirty RAM when the OSD opens.
module bk_sd_sequencer
    import bk_pkg::*;
#(
    parameter int SECTORS = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        img_mounted,
    input  logic [31:0] img_size,
    input  logic        rom_download,
    input  logic        save_req,
    input  logic        nvram_we,
    input  logic        osd_open,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    output logic        bk_ena,
    output logic        bk_busy,
    output logic        bk_reset,
    output logic [2:0]  dbg_state
);

    localparam int LBA_W = (SECTORS > 1) ? $clog2(SECTORS) : 1;
    localparam logic [LBA_W-1:0] LAST_LBA = LBA_W'(SECTORS - 1);

    bk_state_t        state;
    logic [LBA_W-1:0] lba;
    logic             pending;
    logic             dirty;
    logic             is_load;
    logic             abort;

    logic mount_q, save_q, rom_q, ack_q;
    logic mount_ok, save_rise, rom_rise, ack_rise, ack_fall, auto_go;

    assign mount_ok  = img_mounted & ~mount_q & (img_size != 32'd0);
    assign save_rise = save_req & ~save_q;
    assign rom_rise  = rom_download & ~rom_q;
    assign ack_rise  = sd_ack & ~ack_q;
    assign ack_fall  = ~sd_ack & ack_q;

`ifdef BK_AUTOSAVE_EN
    logic osd_q;
    assign auto_go = dirty & osd_open & ~osd_q;

    always_ff @(posedge clk_sys) begin
        if (reset) osd_q <= 1'b0;
        else       osd_q <= osd_open;
    end
`else
    logic unused_autosave;
    assign unused_autosave = osd_open ^ nvram_we;
    assign auto_go = 1'b0;
`endif

    assign sd_lba    = 32'(lba);
    assign dbg_state = state;

    // Handshake: sd_rd/sd_wr rise in ISSUE and stay high until the sd_ack rising
    // edge; the sector is complete on the following sd_ack falling edge.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= IDLE;
            lba      <= '0;
            sd_rd    <= 1'b0;
            sd_wr    <= 1'b0;
            bk_ena   <= 1'b0;
            bk_busy  <= 1'b0;
            bk_reset <= 1'b0;
            pending  <= 1'b0;
            dirty    <= 1'b0;
            is_load  <= 1'b0;
            abort    <= 1'b0;
            mount_q  <= 1'b0;
            save_q   <= 1'b0;
            rom_q    <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            mount_q  <= img_mounted;
            save_q   <= save_req;
            rom_q    <= rom_download;
            ack_q    <= sd_ack;
            bk_reset <= 1'b0;

            case (state)
                IDLE: begin
                    abort <= rom_rise;
                    if (bk_ena && pending) begin
                        pending <= 1'b0;
                        is_load <= 1'b1;
                        lba     <= '0;
                        bk_busy <= 1'b1;
                        state   <= ISSUE;
                    end else if (bk_ena && !mount_ok && (save_rise || auto_go)) begin
                        is_load <= 1'b0;
                        lba     <= '0;
                        bk_busy <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (rom_rise) abort <= 1'b1;
                    sd_rd <= is_load;
                    sd_wr <= ~is_load;
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (rom_rise) abort <= 1'b1;
                    if (ack_rise) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (rom_rise) abort <= 1'b1;
                    if (ack_fall) begin
                        // A ROM download abandons the image after the current sector.
                        if (abort || rom_rise) begin
                            bk_busy <= 1'b0;
                            state   <= IDLE;
                        end else if (lba == LAST_LBA) begin
                            state <= FINISH;
                        end else begin
                            lba   <= lba + LBA_W'(1);
                            state <= ISSUE;
                        end
                    end
                end
                FINISH: begin
                    bk_reset <= is_load;
                    dirty    <= 1'b0;
                    bk_busy  <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    sd_rd   <= 1'b0;
                    sd_wr   <= 1'b0;
                    bk_busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase

`ifdef BK_AUTOSAVE_EN
            if (nvram_we) dirty <= 1'b1;
`endif
            // A mount seen mid-transfer stays pending until the next IDLE.
            if (mount_ok) begin
                bk_ena  <= 1'b1;
                pending <= 1'b1;
            end
            if (rom_rise) bk_ena <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bk_sd_sequencer.sv
// Directed-plus-random bench for bk_sd_sequencer: an sd_ack responder, a request
// monitor and an expected request list built from the transfer rules.
module tb_bk_sd_sequencer;
    import bk_pkg::*;

    localparam int SECTORS = 16;
    localparam int BUDGET  = 3000;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        img_mounted = 1'b0;
    logic [31:0] img_size = 32'd0;
    logic        rom_download = 1'b0;
    logic        save_req = 1'b0;
    logic        nvram_we = 1'b0;
    logic        osd_open = 1'b0;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr;
    logic        sd_ack = 1'b0;
    logic        bk_ena, bk_busy, bk_reset;
    logic [2:0]  dbg_state;

    bk_sd_sequencer #(.SECTORS(SECTORS)) dut (
        .clk_sys(clk_sys), .reset(reset), .img_mounted(img_mounted), .img_size(img_size),
        .rom_download(rom_download), .save_req(save_req), .nvram_we(nvram_we),
        .osd_open(osd_open), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .bk_ena(bk_ena), .bk_busy(bk_busy), .bk_reset(bk_reset),
        .dbg_state(dbg_state)
    );

    always #5 clk_sys = ~clk_sys;

    int compared = 0;
    int mismatched = 0;

    // Each entry is {is_write, lba}.
    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];
    int  obs_base = 0;
    int  rst_cnt = 0;
    int  rst_base = 0;
    int  busy_cnt = 0;
    time rst_time = 0;
    time fall_time = 0;
    logic resp_en = 1'b1;
    int  ack_fixed = 0;
    int  late_req = 0;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin : monitor
        logic prev_rd, prev_wr;
        prev_rd = 1'b0;
        prev_wr = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (sd_rd || sd_wr) check("rd_wr_exclusive", 33'(sd_rd & sd_wr), 33'd0);
            if (sd_rd && !prev_rd) obs_q.push_back({1'b0, sd_lba});
            if (sd_wr && !prev_wr) obs_q.push_back({1'b1, sd_lba});
            prev_rd = sd_rd;
            prev_wr = sd_wr;
            if (bk_reset) begin
                rst_cnt++;
                rst_time = $time;
            end
            if (bk_busy) busy_cnt++;
        end
    end

    initial begin : responder
        int late_done;
        int len;
        late_done = 0;
        forever begin
            @(negedge clk_sys);
            if (late_req != late_done) begin
                late_done = late_req;
                sd_ack = 1'b1;
                repeat (5) @(negedge clk_sys);
                sd_ack = 1'b0;
            end else if (resp_en && (sd_rd || sd_wr)) begin
                repeat ($urandom_range(0, 3)) @(negedge clk_sys);
                sd_ack = 1'b1;
                len = (ack_fixed != 0) ? ack_fixed : int'($urandom_range(1, 8));
                repeat (len) @(negedge clk_sys);
                sd_ack = 1'b0;
                fall_time = $time;
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_mount(input logic [31:0] size);
        img_size = size;
        img_mounted = 1'b1;
        @(negedge clk_sys);
        img_mounted = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic pulse_save();
        save_req = 1'b1;
        @(negedge clk_sys);
        save_req = 1'b0;
        @(negedge clk_sys);
    endtask

    // Waits for a quiet bus: not busy and no ack for several consecutive cycles.
    task automatic wait_idle();
        int n;
        int quiet;
        n = 0;
        quiet = 0;
        while (quiet < 4 && n < BUDGET) begin
            @(negedge clk_sys);
            n++;
            if (!bk_busy && !sd_ack) quiet++;
            else quiet = 0;
        end
        check("idle_timeout", 33'(n >= BUDGET), 33'd0);
    endtask

    task automatic add_exp(input logic is_wr, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({is_wr, 32'(i)});
    endtask

    task automatic expect_run(input string tag, input int n_rst);
        check({tag, "_count"}, 33'(obs_q.size() - obs_base), 33'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (obs_base + i < obs_q.size()) check({tag, "_req"}, obs_q[obs_base + i], exp_q[i]);
        check({tag, "_bk_reset"}, 33'(rst_cnt - rst_base), 33'(n_rst));
        obs_base = obs_q.size();
        rst_base = rst_cnt;
        exp_q.delete();
    endtask

    initial begin : main
        int n;
        int busy_snap;
        repeat (3) @(negedge clk_sys);
        check("rst_lba", 33'(sd_lba), 33'd0);
        check("rst_rd", 33'(sd_rd), 33'd0);
        check("rst_wr", 33'(sd_wr), 33'd0);
        check("rst_ena", 33'(bk_ena), 33'd0);
        check("rst_busy", 33'(bk_busy), 33'd0);
        check("rst_bk_reset", 33'(bk_reset), 33'd0);
        check("rst_state", 33'(dbg_state), 33'(IDLE));
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);

        // Save request with no image mounted.
        busy_snap = busy_cnt;
        pulse_save();
        repeat (30) @(negedge clk_sys);
        check("nosave_busy", 33'(busy_cnt - busy_snap), 33'd0);
        expect_run("nosave", 0);

        // Full load with 20-cycle acks.
        ack_fixed = 20;
        pulse_mount(32'd8192);
        wait_idle();
        add_exp(1'b0, SECTORS);
        expect_run("full_load", 1);
        check("load_reset_after_fall", 33'(rst_time > fall_time), 33'd1);
        check("load_busy_after", 33'(bk_busy), 33'd0);
        check("load_ena", 33'(bk_ena), 33'd1);
        ack_fixed = 0;

        // Saves with randomized ack timing.
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(1, 10)) @(negedge clk_sys);
            pulse_save();
            wait_idle();
            add_exp(1'b1, SECTORS);
            expect_run("rand_save", 0);
        end

        nvram_we = 1'b1;
        @(negedge clk_sys);
        nvram_we = 1'b0;
        repeat (3) @(negedge clk_sys);
        osd_open = 1'b1;
        repeat (3) @(negedge clk_sys);
        osd_open = 1'b0;
`ifdef BK_AUTOSAVE_EN
        wait_idle();
        add_exp(1'b1, SECTORS);
        expect_run("autosave", 0);
        osd_open = 1'b1;
        repeat (3) @(negedge clk_sys);
        osd_open = 1'b0;
        repeat (30) @(negedge clk_sys);
        expect_run("autosave_clean", 0);
`else
        repeat (30) @(negedge clk_sys);
        expect_run("osd_no_save", 0);
`endif

        // ROM download disables the image; zero-size mounts are ignored.
        rom_download = 1'b1;
        repeat (2) @(negedge clk_sys);
        rom_download = 1'b0;
        check("rom_clears_ena", 33'(bk_ena), 33'd0);
        pulse_mount(32'd0);
        repeat (20) @(negedge clk_sys);
        check("zero_mount_ena", 33'(bk_ena), 33'd0);
        expect_run("zero_mount", 0);

        // Mount and save in the same cycle: load wins.
        img_size = $urandom_range(1, 32'h00FF_FFFF);
        img_mounted = 1'b1;
        save_req = 1'b1;
        @(negedge clk_sys);
        img_mounted = 1'b0;
        save_req = 1'b0;
        wait_idle();
        add_exp(1'b0, SECTORS);
        expect_run("mount_and_save", 1);
        check("mount_and_save_ena", 33'(bk_ena), 33'd1);

        // Mount while saving queues a load; a save edge while busy is ignored.
        pulse_save();
        repeat ($urandom_range(20, 60)) @(negedge clk_sys);
        pulse_mount($urandom_range(1, 32'h0000_FFFF));
        repeat (5) @(negedge clk_sys);
        pulse_save();
        wait_idle();
        add_exp(1'b1, SECTORS);
        add_exp(1'b0, SECTORS);
        expect_run("mount_while_busy", 1);

        // ROM download during sector 5 of a load.
        ack_fixed = 20;
        pulse_mount($urandom_range(1, 32'h0000_FFFF));
        n = 0;
        while ((obs_q.size() - obs_base) < 6 && n < BUDGET) begin
            @(negedge clk_sys);
            n++;
        end
        check("abort_timeout", 33'(n >= BUDGET), 33'd0);
        rom_download = 1'b1;
        wait_idle();
        repeat (40) @(negedge clk_sys);
        rom_download = 1'b0;
        add_exp(1'b0, 6);
        expect_run("abort", 0);
        check("abort_ena", 33'(bk_ena), 33'd0);
        ack_fixed = 0;

        // Reset while waiting for ack; a late ack must not restart anything.
        resp_en = 1'b0;
        pulse_mount($urandom_range(1, 32'h0000_FFFF));
        n = 0;
        while (!sd_rd && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        check("wait_ack_timeout", 33'(n >= 50), 33'd0);
        repeat (2) @(negedge clk_sys);
        check("wait_ack_state", 33'(dbg_state), 33'(WAIT_ACK));
        reset = 1'b1;
        @(negedge clk_sys);
        check("reset_rd", 33'(sd_rd), 33'd0);
        check("reset_state", 33'(dbg_state), 33'(IDLE));
        check("reset_busy", 33'(bk_busy), 33'd0);
        reset = 1'b0;
        late_req++;
        repeat (30) @(negedge clk_sys);
        add_exp(1'b0, 1);
        expect_run("late_ack", 0);
        check("late_ack_busy", 33'(bk_busy), 33'd0);
        check("late_ack_ena", 33'(bk_ena), 33'd0);
        resp_en = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bk_sd_sequencer.md
BK_SD_SEQUENCER -- requirements
Module: bk_sd_sequencer

Interface
REQ-001 SHALL have parameter SECTORS, default 16, meaning the number of 512-byte sectors per backup image (8 KiB).
REQ-002 SHALL have port clk_sys, input, 1 bit: the single system clock.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port img_mounted, input, 1 bit: level from user_io; its rising edge means a save image was mounted.
REQ-005 SHALL have port img_size, input, 32 bits: size of the mounted image in bytes.
REQ-006 SHALL have port rom_download, input, 1 bit: ROM download in progress.
REQ-007 SHALL have port save_req, input, 1 bit: OSD "Write Save RAM" level; its rising edge requests a save.
REQ-008 SHALL have port nvram_we, input, 1 bit: core write strobe to backup RAM.
REQ-009 SHALL have port osd_open, input, 1 bit: OSD visible; used only with BK_AUTOSAVE_EN.
REQ-010 SHALL have port sd_lba, output, 32 bits: sector address.
REQ-011 SHALL have ports sd_rd and sd_wr, outputs, 1 bit each: sector read and write requests.
REQ-012 SHALL have port sd_ack, input, 1 bit: high while user_io services the current sector.
REQ-013 SHALL have port bk_ena, output, 1 bit: a valid save image is mounted.
REQ-014 SHALL have port bk_busy, output, 1 bit: a transfer is in progress.
REQ-015 SHALL have port bk_reset, output, 1 bit: one-cycle core-reset pulse issued after a load completes.

Function
REQ-016 SHALL detect all rising edges using registered copies of the inputs, so a detected edge is acted on one cycle after the input changes.
REQ-017 SHALL use the states IDLE, ISSUE, WAIT_ACK, WAIT_DONE and FINISH.
REQ-018 SHALL set bk_ena and latch a pending load when img_mounted rises with img_size!=0; a mount with img_size==0 SHALL change nothing.
REQ-019 SHALL clear bk_ena when rom_download rises.
REQ-020 SHALL, in IDLE with bk_ena=1:
- start a load if a load is pending;
- otherwise start a save on a save_req edge.
REQ-021 SHALL, on starting either transfer, set sd_lba=0, latch the direction, and go to ISSUE.
REQ-022 SHALL, in ISSUE, assert sd_rd (load) or sd_wr (save) and go to WAIT_ACK.
REQ-023 SHALL, in WAIT_ACK, hold the request until sd_ack rises, clear sd_rd and sd_wr on that edge, and go to WAIT_DONE.
REQ-024 SHALL, in WAIT_DONE on the falling edge of sd_ack:
- if sd_lba==SECTORS-1, go to FINISH;
- otherwise increment sd_lba and return to ISSUE.
REQ-025 SHALL, in FINISH, pulse bk_reset for exactly one cycle if the transfer was a load, clear dirty, and return to IDLE.
REQ-026 SHALL hold bk_busy=1 in every state except IDLE.
REQ-027 SHALL give a load priority over a save when both arrive in the same cycle; that save is dropped.
REQ-028 SHALL ignore save edges that arrive while busy.
REQ-029 SHALL latch a mount edge that arrives while busy as a pending load, which starts on the next return to IDLE.
REQ-030 SHALL, if rom_download rises mid-transfer, finish the current sector, then go to IDLE with no bk_reset pulse and the remaining sectors abandoned.
REQ-031 SHALL never assert sd_rd and sd_wr together.
REQ-032 SHALL make sd_lba wide enough to hold SECTORS-1, zero-extended to 32 bits.

Reset
REQ-033 SHALL, on reset, set the state to IDLE.
REQ-034 SHALL, on reset, drive sd_lba=0, sd_rd=0, sd_wr=0, bk_ena=0, bk_busy=0, bk_reset=0.
REQ-035 SHALL, on reset, clear the pending load, the dirty flag and all edge registers.
REQ-036 SHALL, on reset asserted mid-transfer, drop the outstanding request immediately; the sd_ack still in flight SHALL be ignored.

Configuration
REQ-037 SHALL, with BK_AUTOSAVE_EN defined:
- set dirty on any nvram_we;
- in IDLE with bk_ena=1, dirty=1 and no pending load, start a save on an osd_open rising edge.
REQ-038 SHALL, without BK_AUTOSAVE_EN, not use osd_open, and save only on save_req.

Structure
REQ-039 SHALL place the state enum type and the constant SECTOR_BYTES=512 in a shared package, bk_pkg.
REQ-040 SHALL be implemented as a single module with no sub-modules; edge detection and the sector counter stay inline.

Verification
REQ-041 SHALL cover a full load:
- stimulus: img_mounted edge with img_size=8192; each sd_rd answered with an sd_ack pulse 20 cycles long;
- required response: 16 reads with sd_lba 0..15, one bk_reset pulse after the last sd_ack fall, bk_busy low after that.
REQ-042 SHALL cover a save edge with bk_ena=0: no sd_wr, and bk_busy stays 0.
REQ-043 SHALL cover a mount and a save edge in the same cycle: a load runs and no sd_wr is issued.
REQ-044 SHALL cover rom_download rising during sector 5 of a load:
- sector 5 completes;
- no sector 6 request and no bk_reset;
- bk_ena=0.
REQ-045 SHALL cover reset asserted in WAIT_ACK:
- next cycle sd_rd=0 and state IDLE;
- a late sd_ack causes no further requests.
REQ-046 SHALL cover BK_AUTOSAVE_EN:
- nvram_we pulse, then osd_open edge, gives 16 writes;
- a second osd_open edge with no new writes gives no write.
